avalon_pio_blink_out: RTL

//  Parametrised Avalon-MM slave output PIO driving board LEDs; successor to the fixed 18-bit LED port.
//  - Adds atomic bit set/clear registers, per-bit blink enable and a programmable blink prescaler.
//  - Sits on the Nios II data bus beside the other PIOs; out_port goes straight to the LED pins.

---
 rtl/avalon_pio_blink_out_if.sv | 17 +
 rtl/avalon_pio_blink_out.sv | 107 ++++++++++
 2 files changed

// File: rtl/avalon_pio_blink_out_if.sv
// Avalon-MM slave bus bundle for the blinking LED PIO.
//   chipselect : slave select
//   address    : 3-bit word address
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, zero latency
// master drives the request side; slave returns readdata.
interface avalon_pio_blink_out_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output chipselect, address, write_n, writedata, input readdata);
  modport slave  (input chipselect, address, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_pio_blink_out.sv
// Avalon-MM output PIO for board LEDs with atomic set/clear, per-bit blink
// enable and a programmable blink prescaler.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (chipselect, address, write_n, writedata, readdata)
//   out_port : registered LED drive, WIDTH bits
//
// state  | meaning
// -------+-------------------------------------------------------
// phase  | blink phase, 1 = blinking bits lit; flips when cnt hits period
// cnt    | prescaler count, 0..period, cleared by any PERIOD write
module avalon_pio_blink_out #(
  parameter int                 WIDTH        = 18,
  parameter int                 PRESC_W      = 24,
  parameter logic [WIDTH-1:0]   RESET_DATA   = '0,
  parameter logic [PRESC_W-1:0] RESET_PERIOD = PRESC_W'(2499999)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  avalon_pio_blink_out_if.slave     bus,
  output logic [WIDTH-1:0]          out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLEAR  = 3'd2;
  localparam logic [2:0] A_MODE   = 3'd3;
  localparam logic [2:0] A_PERIOD = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mode_q, mode_d;
  logic [PRESC_W-1:0] period_q, period_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [31:0]        rd_data;
  logic               wr;
  logic [WIDTH-1:0]   wd_w;

  assign wr   = bus.chipselect & ~bus.write_n;
  assign wd_w = bus.writedata[WIDTH-1:0];

  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    period_d = period_q;
    if (wr) begin
      case (bus.address)
        A_DATA:   data_d   = wd_w;
        A_SET:    data_d   = data_q | wd_w;
        A_CLEAR:  data_d   = data_q & ~wd_w;
        A_MODE:   mode_d   = wd_w;
        A_PERIOD: period_d = bus.writedata[PRESC_W-1:0];
        default:  ;
      endcase
    end
  end

  // A PERIOD write restarts the count and holds the phase, overriding the
  // terminal-count toggle of the same cycle.
  always_comb begin
    cnt_d   = cnt_q + PRESC_W'(1);
    phase_d = phase_q;
    if (wr && bus.address == A_PERIOD) begin
      cnt_d = '0;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  assign out_d = data_q & (~mode_q | {WIDTH{phase_q}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_DATA;
      mode_q   <= '0;
      period_q <= RESET_PERIOD;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      out_q    <= RESET_DATA;
    end else begin
      data_q   <= data_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.address)
      A_DATA:   rd_data[WIDTH-1:0]   = data_q;
      A_MODE:   rd_data[WIDTH-1:0]   = mode_q;
      A_PERIOD: rd_data[PRESC_W-1:0] = period_q;
      A_STATUS: rd_data[0]           = phase_q;
      default:  ;
    endcase
  end

  assign bus.readdata = rd_data;
  assign out_port     = out_q;

endmodule
